// File: rtl/smips_pkg.sv
// Shared fetch-side types and constants for the smips core.
// Holds the fetch FSM state enum, word size and default reset PC.
package smips_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Byte address -> word address, upper bits zero-filled.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer between instruction memory data and decode.
// Ports: clk, reset (sync, active-low), data/valid in, stall, flush; instr_out, held.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        valid,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_out,
  output logic        held
);

  logic [31:0] hold_reg;
  logic        hold_valid;

  // The memory keeps returning the next word while stalled, so the
  // presented word must be captured on the first stalled edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (valid && stall && !hold_valid) begin
      hold_reg   <= data;
      hold_valid <= 1'b1;
    end else if (valid && !stall) begin
      hold_valid <= 1'b0;
    end
  end

  assign instr_out = hold_valid ? hold_reg : data;
  assign held      = hold_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle-latency instruction memory,
// presents instr_out/pc_out/instr_valid to decode with stall, redirect, halt.
// Ports: clk, reset (sync, active-low), i_addr, instruction, stall, redirect,
// redirect_pc, halt, instr_out, pc_out, instr_valid.
// Optional macro FETCH_PERF_EN adds fetch_count and stall_count outputs.
module instruction_fetch
  import smips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              flush;
  logic              held;

  assign pc_inc = pc + ADDR_W'(WORD_BYTES);
  assign target = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FILL;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = req_pc;
    unique case (state)
      FILL: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (redirect) begin
          pc_nxt = target;
        end else begin
          state_nxt = RUN;
          req_nxt   = pc;
          pc_nxt    = pc_inc;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (redirect) begin
          state_nxt = FILL;
          pc_nxt    = target;
        end else if (!stall) begin
          req_nxt = pc;
          pc_nxt  = pc_inc;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Redirect squashes the in-flight word; halt drops whatever is held.
  assign flush = (state != HALTED) && (halt || redirect);

  assign instr_valid = (state == RUN);
  assign pc_out      = req_pc;
  assign i_addr      = {2'b00, pc[ADDR_W-1:2]};

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .data      (instruction),
    .valid     (instr_valid),
    .stall     (stall),
    .flush     (flush),
    .instr_out (instr_out),
    .held      (held)
  );

`ifdef FETCH_PERF_EN
  // instr_valid is low in HALTED, so both counters freeze there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (instr_valid) begin
      if (stall) begin
        stall_count <= stall_count + 32'd1;
      end else begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch.
// Two DUTs: RESET_PC=0 for the main table, RESET_PC=FFFF_FFF8 for wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        reset, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] i_addr, instruction, instr_out, pc_out;
  logic        instr_valid;

  logic        rst1;
  logic [31:0] i_addr1, instruction1, instr_out1, pc_out1;
  logic        instr_valid1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .i_addr      (i_addr),
    .instruction (instruction),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fc0),
    .stall_count (sc0)
`endif
  );

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk         (clk),
    .reset       (rst1),
    .i_addr      (i_addr1),
    .instruction (instruction1),
    .stall       (zero),
    .redirect    (zero),
    .redirect_pc (zero32),
    .halt        (zero),
    .instr_out   (instr_out1),
    .pc_out      (pc_out1),
    .instr_valid (instr_valid1)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fc1),
    .stall_count (sc1)
`endif
  );

  // Synchronous-read memories: w[k] = 1000_0000 + k.
  always @(posedge clk) begin
    instruction  <= 32'h1000_0000 + i_addr;
    instruction1 <= 32'h1000_0000 + i_addr1;
  end

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        hlt;
    logic        ev;
    logic        cpc;
    logic [31:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic rdr,
    input logic [31:0] rpc, input logic hlt, input logic ev,
    input logic cpc, input logic [31:0] epc, input logic [31:0] ein);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
    v.ev = ev; v.cpc = cpc; v.epc = epc; v.ein = ein;
    return v;
  endfunction

  function automatic logic [31:0] w(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    // Each row: expected outputs this cycle, inputs for the next edge.
    tv[0]  = mk(1,0,0,0,0,      0,1,32'h0,  0);
    tv[1]  = mk(1,0,0,0,0,      1,1,32'h0,  w(0));
    tv[2]  = mk(1,0,0,0,0,      1,1,32'h4,  w(1));
    tv[3]  = mk(1,1,0,0,0,      1,1,32'h8,  w(2));
    tv[4]  = mk(1,1,0,0,0,      1,1,32'h8,  w(2));
    tv[5]  = mk(1,1,0,0,0,      1,1,32'h8,  w(2));
    tv[6]  = mk(1,0,0,0,0,      1,1,32'h8,  w(2));
    tv[7]  = mk(1,0,0,0,0,      1,1,32'hC,  w(3));
    tv[8]  = mk(1,0,1,32'h43,0, 1,1,32'h10, w(4));
    tv[9]  = mk(1,0,0,0,0,      0,0,32'h0,  0);
    tv[10] = mk(1,0,0,0,0,      1,1,32'h40, w(16));
    tv[11] = mk(1,1,0,0,0,      1,1,32'h44, w(17));
    tv[12] = mk(1,1,1,32'h100,0,1,1,32'h44, w(17));
    tv[13] = mk(1,1,0,0,0,      0,0,32'h0,  0);
    tv[14] = mk(1,0,0,0,0,      1,1,32'h100,w(64));
    tv[15] = mk(1,0,0,0,1,      1,1,32'h104,w(65));
    tv[16] = mk(1,0,1,32'h200,0,0,0,32'h0,  0);
    tv[17] = mk(1,1,0,0,0,      0,0,32'h0,  0);
    tv[18] = mk(0,0,0,0,0,      0,0,32'h0,  0);
    tv[19] = mk(1,0,0,0,0,      0,1,32'h0,  0);
    tv[20] = mk(1,0,0,0,0,      1,1,32'h0,  w(0));
    tv[21] = mk(1,1,0,0,0,      1,1,32'h4,  w(1));
    tv[22] = mk(0,1,0,0,0,      1,1,32'h4,  w(1));
    tv[23] = mk(1,0,0,0,0,      0,1,32'h0,  0);
    tv[24] = mk(1,0,0,0,0,      1,1,32'h0,  w(0));

    reset = 0; stall = 0; redirect = 0; halt = 0; redirect_pc = 0;
    rst1 = 0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("r%0d valid", i), 32'(instr_valid), 32'(tv[i].ev));
      if (tv[i].cpc)
        chk($sformatf("r%0d pc_out", i), pc_out, tv[i].epc);
      if (tv[i].ev)
        chk($sformatf("r%0d instr", i), instr_out, tv[i].ein);
      reset       = tv[i].rst;
      stall       = tv[i].stl;
      redirect    = tv[i].rdr;
      redirect_pc = tv[i].rpc;
      halt        = tv[i].hlt;
    end

    // Wrap-around sequence on the second instance.
    @(negedge clk);
    chk("wrap rst valid", 32'(instr_valid1), 32'd0);
    chk("wrap rst pc", pc_out1, 32'hFFFF_FFF8);
    chk("wrap rst iaddr", i_addr1, 32'h3FFF_FFFE);
    rst1 = 1;
    @(negedge clk);
    chk("wrap0 valid", 32'(instr_valid1), 32'd1);
    chk("wrap0 pc", pc_out1, 32'hFFFF_FFF8);
    chk("wrap0 instr", instr_out1, 32'h4FFF_FFFE);
    @(negedge clk);
    chk("wrap1 pc", pc_out1, 32'hFFFF_FFFC);
    chk("wrap1 instr", instr_out1, 32'h4FFF_FFFF);
    @(negedge clk);
    chk("wrap2 pc", pc_out1, 32'h0000_0000);
    chk("wrap2 instr", instr_out1, 32'h1000_0000);
    @(negedge clk);
    chk("wrap3 pc", pc_out1, 32'h0000_0004);
`ifdef FETCH_PERF_EN
    chk("wrap fetch_count", fc1, 32'd3);
    chk("wrap stall_count", sc1, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
